// File: rtl/op_dispatcher_pkg.sv
// Shared types for the operation dispatcher: core opcodes, queued command record
// and dispatcher FSM states.
package op_dispatcher_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_LOAD,
        OP_STORE
    } opcode;

    typedef struct packed {
        opcode       op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } disp_state_t;

    // Timer never narrower than 8 bits so small TIMEOUT values still saturate cleanly.
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/op_dispatcher_cmd_fifo.sv
// Command FIFO of cmd_t records; pointers carry an extra wrap bit to tell full from empty.
module op_dispatcher_cmd_fifo
    import op_dispatcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t       mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/op_dispatcher.sv
// Command-queue front end for the core: issues queued operations one at a time,
// waits for end_op (or a timeout) and presents the result on a valid/ready port.
module op_dispatcher
    import op_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  opcode       cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [11:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        start_op,
    output opcode       op_sel,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [11:0] address_in,
    output logic [7:0]  data_in,
    input  logic        end_op,
    input  logic [15:0] result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output opcode       res_op,
    output logic        res_err,
    output logic        busy
);

    localparam int              TW         = timer_width(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TIMER_MAX  = {TW{1'b1}};

    disp_state_t            state_reg, state_next;
    cmd_t                   cur_reg, cur_next;
    logic                   start_reg, start_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic                   res_valid_reg, res_valid_next;
    logic [15:0]            res_data_reg, res_data_next;
    opcode                  res_op_reg, res_op_next;
    logic                   res_err_reg, res_err_next;

    cmd_t                   cmd_in;
    cmd_t                   fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;

    assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, addr: cmd_addr, data: cmd_data};

    // A pending result blocks the next issue, so acceptance and capture never overlap.
    assign fifo_pop = (state_reg == IDLE) && !fifo_empty && !res_valid_reg;

    op_dispatcher_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        start_next     = start_reg;
        timer_next     = timer_reg;
        res_valid_next = res_valid_reg && !res_ready;
        res_data_next  = res_data_reg;
        res_op_next    = res_op_reg;
        res_err_next   = res_err_reg;
        case (state_reg)
            IDLE: begin
                if (fifo_pop) begin
                    cur_next   = fifo_head;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start_next = 1'b1;
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (end_op) begin
                    res_data_next  = result;
                    res_op_next    = cur_reg.op;
                    res_err_next   = 1'b0;
                    res_valid_next = 1'b1;
                    start_next     = 1'b0;
                    state_next     = GAP;
                end else if (timer_reg >= TIMER_LAST) begin
                    res_data_next  = '0;
                    res_op_next    = cur_reg.op;
                    res_err_next   = 1'b1;
                    res_valid_next = 1'b1;
                    start_next     = 1'b0;
                    state_next     = GAP;
                end else if (timer_reg != TIMER_MAX) begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            GAP: begin
                // Wait for the core to drop end_op before anything new is issued.
                start_next = 1'b0;
                if (!end_op) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            start_reg     <= 1'b0;
            timer_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_op_reg    <= opcode'(0);
            res_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            start_reg     <= start_next;
            timer_reg     <= timer_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_op_reg    <= res_op_next;
            res_err_reg   <= res_err_next;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign start_op   = start_reg;
    assign op_sel     = cur_reg.op;
    assign A          = cur_reg.a;
    assign B          = cur_reg.b;
    assign address_in = cur_reg.addr;
    assign data_in    = cur_reg.data;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_op     = res_op_reg;
    assign res_err    = res_err_reg;
    assign busy       = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher: a vector table for single operations plus
// hand-written sequences for back-to-back, FIFO-full, timeout, backpressure and reset.
module tb_op_dispatcher;
    import op_dispatcher_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    opcode       cmd_op = OP_NOP;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        start_op;
    opcode       op_sel;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [11:0] address_in;
    logic [7:0]  data_in;
    logic        end_op = 1'b0;
    logic [15:0] result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    opcode       res_op;
    logic        res_err;
    logic        busy;

    int          vec_count   = 0;
    int          miscompares = 0;
    logic [7:0]  core_mem [int];
    opcode       exp_op_q [$];
    logic [15:0] exp_res_q [$];

    typedef struct {
        opcode       op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] addr;
        logic [7:0]  data;
        int          lat;
        logic [15:0] res;
    } vec_t;

    vec_t tbl [4];

    op_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .start_op   (start_op),
        .op_sel     (op_sel),
        .A          (A),
        .B          (B),
        .address_in (address_in),
        .data_in    (data_in),
        .end_op     (end_op),
        .result     (result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input opcode op, input logic [7:0] a, input logic [7:0] b,
                        input logic [11:0] addr, input logic [7:0] data, output bit acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_addr  = addr;
        cmd_data  = data;
        acc       = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int cyc);
        cyc = 0;
        while (!start_op && cyc < limit) begin
            tick();
            cyc++;
        end
        if (!start_op) begin
            vec_count++;
            miscompares++;
            $display("FAIL start_op wait: still 0 after %0d cycles, expected 1", limit);
        end
    endtask

    // Behavioural core: arithmetic on the operand bus and a sparse byte memory.
    function automatic logic [15:0] core_calc(input cmd_t c);
        case (c.op)
            OP_ADD:   return 16'(c.a) + 16'(c.b);
            OP_AND:   return {8'h00, c.a & c.b};
            OP_XOR:   return {8'h00, c.a ^ c.b};
            OP_LOAD:  return core_mem.exists(int'(c.addr)) ? {8'h00, core_mem[int'(c.addr)]} : 16'h0000;
            OP_STORE: begin
                core_mem[int'(c.addr)] = c.data;
                return 16'h0000;
            end
            default:  return 16'h0000;
        endcase
    endfunction

    // Answers each issued op after `stall` extra cycles and scores results in order.
    task automatic run_core(input int n, input int stall);
        int   got = 0;
        int   high_cnt = 0;
        int   low_cnt = 0;
        bit   seen_start = 1'b0;
        bit   stable = 1'b1;
        cmd_t snap = '0;
        cmd_t bus;
        for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
            bus = '{op: op_sel, a: A, b: B, addr: address_in, data: data_in};
            if (res_valid && res_ready) begin
                if (exp_op_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("FAIL extra result: got %0h, expected none", res_data);
                end else begin
                    check("seq res_op", 32'(res_op), 32'(exp_op_q.pop_front()));
                    check("seq res_data", 32'(res_data), 32'(exp_res_q.pop_front()));
                    check("seq res_err", 32'(res_err), 32'd0);
                end
                $display("result %0d: op=%s data=%h err=%0d", got, res_op.name(), res_data, res_err);
                got++;
            end
            end_op = 1'b0;
            result = '0;
            if (start_op) begin
                if (high_cnt == 0) begin
                    snap = bus;
                    if (seen_start) check("start_op gap between ops", 32'(low_cnt >= 1), 32'd1);
                end else if (bus != snap) begin
                    stable = 1'b0;
                end
                high_cnt++;
                if (high_cnt == stall + 1) begin
                    end_op = 1'b1;
                    result = core_calc(bus);
                end
                seen_start = 1'b1;
                low_cnt    = 0;
            end else begin
                high_cnt = 0;
                low_cnt++;
            end
            tick();
        end
        end_op = 1'b0;
        result = '0;
        check("results received", 32'(got), 32'(n));
        check("operands stable in WAIT", 32'(stable), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int cyc;
        int hc;
        bit started;
        bit stable;

        tbl[0] = '{OP_ADD,   8'hFF, 8'hFE, 12'h000, 8'h00, 3, 16'h01FD};
        tbl[1] = '{OP_XOR,   8'h5A, 8'hA5, 12'h000, 8'h00, 0, 16'h00FF};
        tbl[2] = '{OP_STORE, 8'h00, 8'h00, 12'h7FF, 8'h3C, 1, 16'h0000};
        tbl[3] = '{OP_LOAD,  8'h00, 8'h00, 12'hFFF, 8'h00, 5, 16'h00C3};

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("reset start_op", 32'(start_op), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset op_sel", 32'(op_sel), 32'd0);
        check("reset res_data", 32'(res_data), 32'd0);
        rst = 1'b1;
        tick();
        check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

        // Single operations from the vector table
        for (int i = 0; i < 4; i++) begin
            push(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].addr, tbl[i].data, acc);
            check("table push accepted", 32'(acc), 32'd1);
            wait_start(10, cyc);
            check("issue latency", 32'(cyc), 32'd2);
            check("op_sel", 32'(op_sel), 32'(tbl[i].op));
            check("A", 32'(A), 32'(tbl[i].a));
            check("B", 32'(B), 32'(tbl[i].b));
            check("address_in", 32'(address_in), 32'(tbl[i].addr));
            check("data_in", 32'(data_in), 32'(tbl[i].data));
            stable = 1'b1;
            for (int k = 0; k < tbl[i].lat; k++) begin
                tick();
                if (!start_op || A !== tbl[i].a || address_in !== tbl[i].addr) stable = 1'b0;
            end
            check("table WAIT hold", 32'(stable), 32'd1);
            end_op = 1'b1;
            result = tbl[i].res;
            tick();
            end_op = 1'b0;
            result = '0;
            check("res_valid after end_op", 32'(res_valid), 32'd1);
            check("res_data", 32'(res_data), 32'(tbl[i].res));
            check("res_op", 32'(res_op), 32'(tbl[i].op));
            check("res_err", 32'(res_err), 32'd0);
            check("start_op after end_op", 32'(start_op), 32'd0);
            $display("vector %0d: op=%s data=%h err=%0d", i, res_op.name(), res_data, res_err);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("res_valid after accept", 32'(res_valid), 32'd0);
            cyc = 0;
            while (busy && cyc < 10) begin
                tick();
                cyc++;
            end
            check("idle after vector", 32'(busy), 32'd0);
        end

        // Back-to-back STORE then LOAD with the consumer always ready
        res_ready = 1'b1;
        push(OP_STORE, 8'h00, 8'h00, 12'h011, 8'hFE, acc);
        exp_op_q.push_back(OP_STORE); exp_res_q.push_back(16'h0000);
        push(OP_LOAD, 8'h00, 8'h00, 12'h011, 8'h00, acc);
        exp_op_q.push_back(OP_LOAD);  exp_res_q.push_back(16'h00FE);
        run_core(2, 1);
        res_ready = 1'b0;

        // FIFO full while the core stalls on the first op
        push(OP_ADD, 8'h10, 8'h20, 12'h000, 8'h00, acc);
        exp_op_q.push_back(OP_ADD); exp_res_q.push_back(16'h0030);
        wait_start(10, cyc);
        for (int i = 0; i <= DEPTH; i++) begin
            push(OP_ADD, 8'(i + 1), 8'h30, 12'h000, 8'h00, acc);
            check("fifo accept", 32'(acc), 32'(i < DEPTH));
            if (i < DEPTH) begin
                exp_op_q.push_back(OP_ADD);
                exp_res_q.push_back(16'h0031 + 16'(i));
            end
        end
        check("cmd_ready when full", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        run_core(DEPTH + 1, 0);
        started = 1'b0;
        repeat (10) begin
            tick();
            if (start_op) started = 1'b1;
        end
        check("dropped cmd never issued", 32'(started), 32'd0);
        check("idle after drain", 32'(busy), 32'd0);
        res_ready = 1'b0;

        // Timeout on a hung core, then the queued op proceeds
        push(OP_ADD, 8'h01, 8'h02, 12'h000, 8'h00, acc);
        push(OP_AND, 8'hF0, 8'h3C, 12'h000, 8'h00, acc);
        wait_start(10, cyc);
        hc = 0;
        while (start_op && hc < 1000) begin
            tick();
            hc++;
        end
        check("cycles in WAIT before timeout", 32'(hc), 32'(TIMEOUT));
        check("timeout res_valid", 32'(res_valid), 32'd1);
        check("timeout res_err", 32'(res_err), 32'd1);
        check("timeout res_data", 32'(res_data), 32'd0);
        check("timeout res_op", 32'(res_op), 32'(OP_ADD));
        $display("timeout: op=%s data=%h err=%0d after %0d cycles", res_op.name(), res_data, res_err, hc);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        wait_start(10, cyc);
        check("op after timeout", 32'(op_sel), 32'(OP_AND));
        check("A after timeout", 32'(A), 32'h0000_00F0);
        end_op = 1'b1;
        result = 16'h0030;
        tick();
        end_op = 1'b0;
        result = '0;
        check("post-timeout res_err", 32'(res_err), 32'd0);
        check("post-timeout res_data", 32'(res_data), 32'h0000_0030);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // Result backpressure blocks the next issue
        push(OP_XOR, 8'h0F, 8'hFF, 12'h000, 8'h00, acc);
        push(OP_ADD, 8'h02, 8'h03, 12'h000, 8'h00, acc);
        wait_start(10, cyc);
        end_op = 1'b1;
        result = 16'h00F0;
        tick();
        end_op = 1'b0;
        result = '0;
        started = 1'b0;
        repeat (10) begin
            tick();
            if (start_op) started = 1'b1;
        end
        check("no issue while result pending", 32'(started), 32'd0);
        check("result held", 32'(res_valid), 32'd1);
        check("held res_data", 32'(res_data), 32'h0000_00F0);
        check("busy while queued", 32'(busy), 32'd1);
        $display("backpressure: op=%s data=%h held", res_op.name(), res_data);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        wait_start(10, cyc);
        check("second op after accept", 32'(op_sel), 32'(OP_ADD));

        // Asynchronous reset in the middle of WAIT
        #2;
        rst = 1'b0;
        #1;
        check("start_op drops on async reset", 32'(start_op), 32'd0);
        check("res_valid on async reset", 32'(res_valid), 32'd0);
        check("busy on async reset", 32'(busy), 32'd0);
        check("op_sel on async reset", 32'(op_sel), 32'd0);
        check("cmd_ready on async reset", 32'(cmd_ready), 32'd1);
        tick();
        rst = 1'b1;
        started = 1'b0;
        repeat (10) begin
            tick();
            if (start_op) started = 1'b1;
        end
        check("in-flight op lost after reset", 32'(started), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
